// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer that registers
// ready_o, stage hold and a synchronous flush. Optional stall counter: define PIPE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        state_dbg
);

  // Handshake: a payload moves across an interface only in a cycle where valid and ready
  // are both 1 at the rising edge; the sender holds the payload stable until then.
  // hold_i masks ready_i on the output side only.

  // State encoding is {out_valid, skid_valid}, so valid_o and ready_o come straight off flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign valid_o   = state_q[1];
  assign ready_o   = ~state_q[0];
  assign data_o    = out_q;
  assign state_dbg = state_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i & ~hold_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      out_q   <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      out_d   = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            out_d   = data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_d = data_i;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = data_i;
          end else if (out_fire) begin
            // Bubble: reload with NOP so data_o never shows a stale payload.
            state_d = EMPTY;
            out_d   = NOP_VALUE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            out_d   = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          out_d   = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !out_fire && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table, hand sequences for async reset and
// stall counter, and a queue scoreboard over a random back-pressure stream.
module tb_pipe_stage_reg;

  localparam int                DATA_W = 32;
  localparam int                CNT_W  = 2;
  localparam logic [DATA_W-1:0] NOP    = 32'hDEAD_BEEF;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic              hold_i;
  logic              flush_i;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .stall_cnt_o (stall_cnt_o),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              h;
    logic              f;
    logic              ev;
    logic [DATA_W-1:0] ed;
    logic              er;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic v, input logic [DATA_W-1:0] d, input logic r,
                              input logic h, input logic f, input logic ev,
                              input logic [DATA_W-1:0] ed, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.h = h; t.f = f;
    t.ev = ev; t.ed = ed; t.er = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r,
                       input logic h, input logic f);
    valid_i = v; data_i = d; ready_i = r; hold_i = h; flush_i = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] exp_stall(input int n);
`ifdef PIPE_STALL_CNT_EN
    return (n >= 3) ? CNT_W'(3) : CNT_W'(n);
`else
    return CNT_W'(n * 0);
`endif
  endfunction

  initial begin
    logic [DATA_W-1:0] seq;
    logic in_fire, out_fire;
    int stall_n;

    // stream, back-pressure, hold, skid-under-hold, flush, flush+hold
    vecs[0]  = mk(1, 1,     1, 0, 0, 1, 1,     1);
    vecs[1]  = mk(1, 2,     1, 0, 0, 1, 2,     1);
    vecs[2]  = mk(1, 3,     1, 0, 0, 1, 3,     1);
    vecs[3]  = mk(1, 4,     1, 0, 0, 1, 4,     1);
    vecs[4]  = mk(0, 0,     1, 0, 0, 0, NOP,   1);
    vecs[5]  = mk(1, 'hA,   1, 0, 0, 1, 'hA,   1);
    vecs[6]  = mk(1, 'hB,   0, 0, 0, 1, 'hA,   0);
    vecs[7]  = mk(1, 'hC,   0, 0, 0, 1, 'hA,   0);
    vecs[8]  = mk(1, 'hC,   1, 0, 0, 1, 'hB,   1);
    vecs[9]  = mk(1, 'hC,   1, 0, 0, 1, 'hC,   1);
    vecs[10] = mk(0, 0,     1, 0, 0, 0, NOP,   1);
    vecs[11] = mk(1, 'h55,  1, 0, 0, 1, 'h55,  1);
    vecs[12] = mk(0, 0,     1, 1, 0, 1, 'h55,  1);
    vecs[13] = mk(0, 0,     1, 1, 0, 1, 'h55,  1);
    vecs[14] = mk(0, 0,     1, 1, 0, 1, 'h55,  1);
    vecs[15] = mk(0, 0,     1, 1, 0, 1, 'h55,  1);
    vecs[16] = mk(0, 0,     1, 0, 0, 0, NOP,   1);
    vecs[17] = mk(1, 'h66,  1, 1, 0, 1, 'h66,  1);
    vecs[18] = mk(1, 'h77,  1, 1, 0, 1, 'h66,  0);
    vecs[19] = mk(0, 0,     1, 0, 0, 1, 'h77,  1);
    vecs[20] = mk(0, 0,     1, 0, 0, 0, NOP,   1);
    vecs[21] = mk(1, 'h11,  0, 0, 0, 1, 'h11,  1);
    vecs[22] = mk(1, 'h22,  0, 0, 0, 1, 'h11,  0);
    vecs[23] = mk(1, 'h33,  0, 0, 1, 0, NOP,   1);
    vecs[24] = mk(0, 0,     1, 0, 0, 0, NOP,   1);
    vecs[25] = mk(1, 'h44,  1, 0, 1, 0, NOP,   1);
    vecs[26] = mk(1, 'h12,  1, 0, 0, 1, 'h12,  1);
    vecs[27] = mk(1, 'h34,  1, 1, 1, 0, NOP,   1);
    vecs[28] = mk(0, 0,     1, 0, 0, 0, NOP,   1);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_o", valid_o, 0);
    check("reset data_o", data_o, NOP);
    check("reset ready_o", ready_o, 1);
    check("reset stall_cnt_o", stall_cnt_o, 0);
    rst = 1'b1;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].h, vecs[i].f);
      step();
      check($sformatf("vec%0d valid_o", i), valid_o, vecs[i].ev);
      check($sformatf("vec%0d data_o", i), data_o, vecs[i].ed);
      check($sformatf("vec%0d ready_o", i), ready_o, vecs[i].er);
    end

    // async reset between edges while holding two payloads
    drive(1, 'h81, 0, 0, 0);
    step();
    drive(1, 'h82, 0, 0, 0);
    step();
    check("pre-reset ready_o", ready_o, 0);
    check("pre-reset data_o", data_o, 'h81);
    #3;
    rst = 1'b0;
    #1;
    check("async rst valid_o", valid_o, 0);
    check("async rst data_o", data_o, NOP);
    check("async rst ready_o", ready_o, 1);
    check("async rst stall_cnt_o", stall_cnt_o, 0);
    drive(0, 0, 0, 0, 0);
    step();
    rst = 1'b1;

    // stall counter: load one payload, then stall six cycles
    drive(1, 'h99, 0, 0, 0);
    step();
    check("stall load data_o", data_o, 'h99);
    check("stall load cnt", stall_cnt_o, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("stall cnt %0d", i), stall_cnt_o, exp_stall(i));
      check($sformatf("stall data_o %0d", i), data_o, 'h99);
    end
    stall_n = 7;
    drive(0, 0, 0, 0, 1);
    step();
    check("flush keeps cnt", stall_cnt_o, exp_stall(stall_n));
    check("flush valid_o", valid_o, 0);
    drive(0, 0, 1, 0, 0);
    step();
    check("idle keeps cnt", stall_cnt_o, exp_stall(stall_n));

    // random back-pressure stream against the expected queue
    seq = 32'h1000;
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 3) != 0, seq, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, 0);
      @(negedge clk);
      in_fire  = valid_i & ready_o;
      out_fire = valid_o & ready_i & ~hold_i;
      if (!valid_o) check("sb idle data_o", data_o, NOP);
      if (out_fire) begin
        if (exp_q.size() == 0) check("sb underflow", 1, 0);
        else check("sb data", data_o, exp_q.pop_front());
      end
      if (in_fire) begin
        exp_q.push_back(seq);
        seq = seq + 1;
      end
      step();
    end
    drive(0, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid_o) begin
        if (exp_q.size() == 0) check("drain underflow", 1, 0);
        else check("drain data", data_o, exp_q.pop_front());
      end
      step();
    end
    check("sb queue empty", exp_q.size(), 0);
    check("drain valid_o", valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, successor to the fixed ID/EX-style hold registers. It carries one packed payload bus with a valid/ready handshake, a stage hold, and a synchronous flush that inserts a NOP bubble. An internal 2-entry skid buffer gives a registered ready_o, so back-pressure does not form a combinational path across stages. It is used between any two core stages, such as IF/ID, ID/EX and EX/MEM, by packing the stage fields into data_i.

Parameters:
DATA_W, 32, payload width in bits (>=1)
NOP_VALUE, 0 (DATA_W bits), value driven on data_o whenever valid_o=0; ID/EX instruction field uses `INST_NOP in its slice
CNT_W, 16, width of stall counter (optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
valid_i  in  1  upstream payload valid
data_i  in  DATA_W  upstream payload
ready_o  out  1  stage can accept; registered
valid_o  out  1  downstream payload valid
data_o  out  DATA_W  downstream payload
ready_i  in  1  downstream accepts
hold_i  in  1  stall from control; while 1, treated as ready_i=0
flush_i  in  1  kill all held and incoming payloads
stall_cnt_o  out  CNT_W  output-stall cycle count; 0 without the optional feature

Behaviour:
- Reset (rst=0, async): valid_o=0, data_o=NOP_VALUE, skid empty, ready_o=1, stall_cnt_o=0. Reset mid-transfer drops all contents.
- in_fire = valid_i & ready_o.
- out_fire = valid_o & ready_i & ~hold_i.
- ready_o = ~skid_valid; it is a flop output and never depends combinationally on ready_i or hold_i.
- States, encoded by {out_valid, skid_valid}:
  - EMPTY: in_fire -> ONE, out<=data_i.
  - ONE: in_fire & out_fire -> ONE, out<=data_i. in_fire & ~out_fire -> TWO, skid<=data_i. ~in_fire & out_fire -> EMPTY. Otherwise stay in ONE.
  - TWO: ready_o=0, so no in_fire is possible. out_fire -> ONE, out<=skid. Otherwise stay in TWO.
- Latency: 1 cycle from in_fire to valid_o when the stage is EMPTY, or when ONE with out_fire. Throughput: 1 payload per cycle when ready_i=1 and hold_i=0.
- Ordering is strict FIFO; no payload is ever duplicated or dropped, except on flush or reset.
- data_o is held stable while valid_o=1 and the payload has not been accepted. data_o=NOP_VALUE whenever valid_o=0; a bubble reloads the register with NOP_VALUE.
- flush_i=1 (sync, highest priority): the next state is EMPTY, data_o=NOP_VALUE and ready_o=1. A payload presented on data_i in the flush cycle is discarded, even if in_fire=1. An out_fire in the flush cycle is still valid for the downstream stage.
- flush_i and hold_i together: flush wins.
- hold_i affects only the output side; it does not force ready_o low. The skid absorbs one extra payload, then ready_o drops.
- Widths: all payload paths are exactly DATA_W bits, with no sign or zero extension.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined: stall_cnt_o increments by 1 on every cycle with valid_o=1 and out_fire=0. It saturates at 2^CNT_W-1, is cleared only by reset, and is unaffected by flush.
- Undefined: no counter logic is built and stall_cnt_o is tied to 0.

Test Plan:
- Reset then stream: rst low 3 cycles, then valid_i=1, ready_i=1, data_i=1,2,3,4 -> data_o=1,2,3,4 with valid_o=1, each one cycle later; ready_o stays 1.
- Back-pressure: stream data_i=0xA,0xB,0xC with ready_i=0 from the cycle after 0xA is accepted. Required: 0xA and 0xB are accepted, ready_o=0 on the next cycle, and data_o holds 0xA. Then set ready_i=1: data_o=0xA,0xB,0xC in order, with no loss or duplication.
- Hold: stage in ONE holding 0x55, hold_i=1 for 4 cycles with ready_i=1 -> data_o stays 0x55 and valid_o stays 1. Release -> 0x55 is transferred exactly once.
- Flush: stage in TWO holding 0x11 (out) and 0x22 (skid); assert flush_i with valid_i=1, data_i=0x33 -> next cycle valid_o=0, data_o=NOP_VALUE, ready_o=1, and 0x22 and 0x33 never appear on data_o.
- Async reset mid-operation: assert rst low between clock edges while in TWO -> valid_o=0, data_o=NOP_VALUE and ready_o=1 immediately, before the next edge.
- With PIPE_STALL_CNT_EN and CNT_W=2: hold an output for 6 stalled cycles -> stall_cnt_o=1,2,3,3,3,3. Without the macro: stall_cnt_o=0 throughout.
